// File: rtl/ram_fifo_pkg.sv
// Shared types and helpers for the RAM-backed FIFO controller: FSM states,
// depth derivation and almost-flag thresholds.
package ram_fifo_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLEEP = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  function automatic int depth_f(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic logic almost_empty_f(input int cnt, input int margin);
    return cnt <= margin;
  endfunction

  function automatic logic almost_full_f(input int cnt, input int depth, input int margin);
    return cnt >= (depth - margin);
  endfunction

endpackage

// File: rtl/ram_fifo_ptr.sv
// Wrapping RAM address pointer with increment enable and synchronous clear;
// clear wins over increment.
module ram_fifo_ptr #(
  parameter int ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_fifo_ctl.sv
// FIFO controller in front of a RAM primitive: push/pop to RAM strobes,
// occupancy and status flags, sticky errors and idle power-down sequencing.
module ram_fifo_ctl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int AE_MARGIN   = 4,
  parameter int AF_MARGIN   = 4,
  parameter int IDLE_CYCLES = 16
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              PUSH,
  input  logic              POP,
  input  logic              FLUSH,
  output logic              READY,
  output logic              WEN,
  output logic [ADDR_W-1:0] WADDR,
  output logic              REN,
  output logic [ADDR_W-1:0] RADDR,
  output logic              RVALID,
  output logic              POWERDN,
  output logic [ADDR_W:0]   COUNT,
  output logic              EMPTY,
  output logic              FULL,
  output logic              ALMOST_EMPTY,
  output logic              ALMOST_FULL,
  output logic              OVERFLOW,
  output logic              UNDERFLOW
);

  localparam int DEPTH  = depth_f(ADDR_W);
  localparam int IDLE_W = $clog2(IDLE_CYCLES + 1) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              empty_q, full_q, ae_q, af_q;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              rvalid_q;
  logic              push_ok, pop_ok, flush_ok;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idle_d   = '0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    push_ok  = 1'b0;
    pop_ok   = 1'b0;
    flush_ok = 1'b0;
    case (state_q)
      ST_RUN: begin
        push_ok = PUSH & ~full_q & ~FLUSH;
        pop_ok  = POP & ~empty_q & ~FLUSH;
        if (FLUSH) begin
          flush_ok = 1'b1;
          cnt_d    = '0;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
        end else begin
          if (PUSH & full_q) ovf_d = 1'b1;
          if (POP & empty_q) unf_d = 1'b1;
          if (push_ok & ~pop_ok)      cnt_d = cnt_q + 1'b1;
          else if (pop_ok & ~push_ok) cnt_d = cnt_q - 1'b1;
        end
        // FIFO is guaranteed empty whenever the idle run reaches the limit.
        if ((IDLE_CYCLES != 0) && empty_q && !PUSH && !POP) begin
          if (int'(idle_q) == IDLE_CYCLES - 1) state_d = ST_SLEEP;
          else                                  idle_d  = idle_q + 1'b1;
        end
      end
      ST_SLEEP: if (PUSH | FLUSH) state_d = ST_WAKE;
      ST_WAKE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= ST_RUN;
      cnt_q    <= '0;
      idle_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= almost_empty_f(0, AE_MARGIN);
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idle_q   <= idle_d;
      empty_q  <= (cnt_d == '0);
      full_q   <= (int'(cnt_d) == DEPTH);
      ae_q     <= almost_empty_f(int'(cnt_d), AE_MARGIN);
      af_q     <= almost_full_f(int'(cnt_d), DEPTH, AF_MARGIN);
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rvalid_q <= pop_ok;
    end
  end

  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk_i (CLK),
    .rst_i (CLR),
    .clr_i (flush_ok),
    .inc_i (push_ok),
    .ptr_o (WADDR)
  );

  ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk_i (CLK),
    .rst_i (CLR),
    .clr_i (flush_ok),
    .inc_i (pop_ok),
    .ptr_o (RADDR)
  );

  assign WEN          = push_ok;
  assign REN          = pop_ok;
  assign READY        = (state_q == ST_RUN);
  assign POWERDN      = (state_q == ST_SLEEP);
  assign RVALID       = rvalid_q;
  assign COUNT        = cnt_q;
  assign EMPTY        = empty_q;
  assign FULL         = full_q;
  assign ALMOST_EMPTY = ae_q;
  assign ALMOST_FULL  = af_q;
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = unf_q;

endmodule
